// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, widths, arbitration states and pixel address helper.
package vga_pkg;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int VRAM_WORDS = H_ACTIVE * V_ACTIVE;
    localparam int DATA_W = 24;
    localparam int ADDR_W = $clog2(VRAM_WORDS);
    localparam int FIFO_DEPTH = 4;
    typedef enum logic [1:0] {ARB_IDLE, ARB_DISP, ARB_HOST} arb_state_t;
    // y*640 + x as (y<<9) + (y<<7) + x so no multiplier is inferred
    function automatic logic [18:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        return {y, 9'd0} + {2'd0, y, 7'd0} + {9'd0, x};
    endfunction
endpackage

// File: rtl/vga_vram_arbiter_if.sv
// vga_vram_arbiter_if: display scan, host write port and VRAM pins of the arbiter.
interface vga_vram_arbiter_if #(
    parameter int DATA_W = vga_pkg::DATA_W,
    parameter int ADDR_W = vga_pkg::ADDR_W
);
    logic              disp_valid;
    logic [9:0]        h_addr;
    logic [9:0]        v_addr;
    logic [DATA_W-1:0] vga_data;
    logic              host_valid;
    logic              host_ready;
    logic [9:0]        host_x;
    logic [9:0]        host_y;
    logic [DATA_W-1:0] host_wdata;
    logic              host_drop;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  disp_valid, h_addr, v_addr, host_valid, host_x, host_y, host_wdata, mem_rdata,
        output vga_data, host_ready, host_drop, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output disp_valid, h_addr, v_addr, host_valid, host_x, host_y, host_wdata, mem_rdata,
        input  vga_data, host_ready, host_drop, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_wr_fifo.sv
// vga_wr_fifo: small synchronous FIFO holding pending host pixel writes.
module vga_wr_fifo #(
    parameter int W = 44,
    parameter int DEPTH = 4
) (
    input  logic                     pclk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    // pointers carry one extra wrap bit so full and empty stay distinct
    assign count = wp - rp;
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = wp == rp;
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge pclk or posedge reset)
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    always_ff @(posedge pclk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/vga_vram_arbiter.sv
// vga_vram_arbiter: shares one VRAM port between display scan-out (absolute priority)
// and FIFO-buffered host pixel writes drained in display-idle cycles.
module vga_vram_arbiter #(
    parameter int DATA_W = vga_pkg::DATA_W,
    parameter int ADDR_W = vga_pkg::ADDR_W,
    parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
    input logic               pclk,
    input logic               reset,
    vga_vram_arbiter_if.slave bus
);
    import vga_pkg::*;
    typedef struct packed {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [DATA_W-1:0] data;
    } entry_t;
    arb_state_t state, nxt;
    entry_t head;
    logic full, empty, pop, in_rng, en_d, we_d, drop_d, rd_v, unused_count;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [$clog2(FIFO_DEPTH):0] count;
    assign bus.host_ready = !full;
    assign in_rng = head.x < 10'(H_ACTIVE) && head.y < 10'(V_ACTIVE);
    assign pop = nxt == ARB_HOST;
    assign unused_count = ^count;
    vga_wr_fifo #(.W($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .pclk  (pclk),
        .reset (reset),
        .push  (bus.host_valid && !full),
        .pop   (pop),
        .din   ({bus.host_x, bus.host_y, bus.host_wdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        nxt = bus.disp_valid ? ARB_DISP : (!empty ? ARB_HOST : ARB_IDLE);
        we_d = nxt == ARB_HOST && in_rng;
        en_d = nxt == ARB_DISP || we_d;
        drop_d = nxt == ARB_HOST && !in_rng;
        addr_d = nxt == ARB_DISP ? ADDR_W'(pix_addr(bus.h_addr, bus.v_addr)) :
                 we_d ? ADDR_W'(pix_addr(head.x, head.y)) : bus.mem_addr;
        wdata_d = we_d ? head.data : bus.mem_wdata;
    end
    always_ff @(posedge pclk or posedge reset)
        if (reset) state <= ARB_IDLE;
        else state <= nxt;
    // state==ARB_DISP is the first read-valid stage, rd_v the second, aligned with mem_rdata
    always_ff @(posedge pclk or posedge reset)
        if (reset) begin
            bus.mem_en <= 1'b0;
            bus.mem_we <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_wdata <= '0;
            bus.host_drop <= 1'b0;
            bus.vga_data <= '0;
            rd_v <= 1'b0;
        end else begin
            bus.mem_en <= en_d;
            bus.mem_we <= we_d;
            bus.mem_addr <= addr_d;
            bus.mem_wdata <= wdata_d;
            bus.host_drop <= drop_d;
            rd_v <= state == ARB_DISP;
            bus.vga_data <= rd_v ? bus.mem_rdata : '0;
        end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// tb_vga_vram_arbiter: directed stimulus with a cycle-tagged scoreboard and a VRAM model.
module tb_vga_vram_arbiter;
    import vga_pkg::*;
    typedef struct { int cyc; logic we; int addr; logic [23:0] wdata; } mop_t;
    typedef struct { int cyc; logic [23:0] val; } vexp_t;
    typedef struct { int x; int y; logic [23:0] d; } hent_t;
    logic clk = 0;
    logic rst = 1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    mop_t exp_mem[$];
    vexp_t exp_vga[$];
    int exp_drop[$];
    hent_t model[$];
    logic [23:0] ram[int];
    mop_t m;
    vexp_t ve;

    always #20 clk = ~clk;

    vga_vram_arbiter_if bus ();
    vga_vram_arbiter dut (.pclk(clk), .reset(rst), .bus(bus));

    function automatic logic [23:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : (24'(a) ^ 24'hC0FFEE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // VRAM model: one-cycle read latency, writes land on the edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram_rd(int'(bus.mem_addr));
        if (bus.mem_en && bus.mem_we) ram[int'(bus.mem_addr)] = bus.mem_wdata;
    end

    always @(negedge clk) if (!rst) begin
        if (bus.mem_en) begin
            if (exp_mem.size() == 0 || exp_mem[0].cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL mem_op: unexpected we=%0b addr=%0d at cycle %0d", bus.mem_we, bus.mem_addr, cyc);
            end else begin
                m = exp_mem.pop_front();
                chk("mem_we", bus.mem_we, m.we);
                chk("mem_addr", bus.mem_addr, m.addr);
                if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
            end
        end
        while (exp_mem.size() != 0 && exp_mem[0].cyc <= cyc) begin
            m = exp_mem.pop_front();
            checks++;
            errors++;
            $display("FAIL mem_op: missing op addr=%0d expected at cycle %0d, got mem_en=0", m.addr, m.cyc);
        end
        if (bus.host_drop) begin
            checks++;
            if (exp_drop.size() == 0 || exp_drop[0] != cyc) begin
                errors++;
                $display("FAIL host_drop: unexpected pulse at cycle %0d", cyc);
            end else void'(exp_drop.pop_front());
        end
        while (exp_drop.size() != 0 && exp_drop[0] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL host_drop: got 0 expected pulse at cycle %0d", exp_drop.pop_front());
        end
        while (exp_vga.size() != 0 && exp_vga[0].cyc <= cyc) begin
            ve = exp_vga.pop_front();
            chk("vga_data", bus.vga_data, ve.val);
        end
    end

    task automatic step(input logic disp, input int h, input int v,
                        input logic hv, input int hx, input int hy, input logic [23:0] hd);
        hent_t e;
        logic full;
        @(posedge clk);
        #1;
        full = model.size() >= FIFO_DEPTH;
        chk("host_ready", bus.host_ready, !full);
        bus.disp_valid = disp;
        bus.h_addr = 10'(h);
        bus.v_addr = 10'(v);
        bus.host_valid = hv;
        bus.host_x = 10'(hx);
        bus.host_y = 10'(hy);
        bus.host_wdata = hd;
        exp_vga.push_back(vexp_t'{cyc + 3, disp ? ram_rd(v * H_ACTIVE + h) : 24'h0});
        if (disp) exp_mem.push_back(mop_t'{cyc + 1, 1'b0, v * H_ACTIVE + h, 24'h0});
        else if (model.size() != 0) begin
            e = model.pop_front();
            if (e.x < H_ACTIVE && e.y < V_ACTIVE)
                exp_mem.push_back(mop_t'{cyc + 1, 1'b1, e.y * H_ACTIVE + e.x, e.d});
            else exp_drop.push_back(cyc + 1);
        end
        if (hv && !full) model.push_back(hent_t'{hx, hy, hd});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0, 24'h0);
    endtask

    initial begin
        bus.disp_valid = 0;
        bus.h_addr = '0;
        bus.v_addr = '0;
        bus.host_valid = 1;
        bus.host_x = 10'd3;
        bus.host_y = 10'd3;
        bus.host_wdata = 24'h111111;
        ram[307199] = 24'h123456;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_vga_data", bus.vga_data, 0);
        chk("rst_host_ready", bus.host_ready, 1);
        chk("rst_host_drop", bus.host_drop, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        rst = 0;
        bus.host_valid = 0;
        idle(3);
        // single blanking write
        step(1'b0, 0, 0, 1'b1, 5, 2, 24'hABCDEF);
        idle(2);
        chk("wr_en", bus.mem_en, 1);
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, 1285);
        chk("wr_data", bus.mem_wdata, 24'hABCDEF);
        idle(2);
        // corner-pixel read and its 3-cycle latency
        step(1'b1, 639, 479, 1'b0, 0, 0, 24'h0);
        idle(1);
        chk("rd_addr", bus.mem_addr, 307199);
        chk("rd_we", bus.mem_we, 0);
        idle(2);
        chk("rd_vga", bus.vga_data, 24'h123456);
        idle(1);
        chk("blank_vga", bus.vga_data, 0);
        step(1'b1, 5, 2, 1'b0, 0, 0, 24'h0);
        step(1'b1, 0, 1, 1'b0, 0, 0, 24'h0);
        idle(4);
        // FIFO fills during active video, drains in order on blanking
        step(1'b1, 20, 100, 1'b1, 10, 10, 24'h000001);
        step(1'b1, 21, 100, 1'b1, 11, 10, 24'h000002);
        step(1'b1, 22, 100, 1'b1, 12, 10, 24'h000003);
        step(1'b1, 23, 100, 1'b1, 0, 479, 24'h000004);
        step(1'b1, 24, 100, 1'b1, 639, 0, 24'h000005);
        step(1'b1, 25, 100, 1'b0, 0, 0, 24'h0);
        chk("full_ready", bus.host_ready, 0);
        idle(7);
        // out-of-range entries are dropped
        step(1'b0, 0, 0, 1'b1, 640, 0, 24'hDEAD01);
        idle(4);
        step(1'b0, 0, 0, 1'b1, 0, 480, 24'hDEAD02);
        idle(4);
        // async reset with entries queued during active video
        step(1'b1, 7, 3, 1'b1, 1, 1, 24'h0000A1);
        step(1'b1, 7, 3, 1'b1, 2, 1, 24'h0000A2);
        step(1'b1, 7, 3, 1'b1, 3, 1, 24'h0000A3);
        step(1'b1, 7, 3, 1'b0, 0, 0, 24'h0);
        step(1'b1, 7, 3, 1'b0, 0, 0, 24'h0);
        #5;
        rst = 1;
        #1;
        chk("arst_mem_en", bus.mem_en, 0);
        chk("arst_mem_we", bus.mem_we, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_mem_wdata", bus.mem_wdata, 0);
        chk("arst_vga_data", bus.vga_data, 0);
        chk("arst_host_ready", bus.host_ready, 1);
        chk("arst_host_drop", bus.host_drop, 0);
        exp_mem.delete();
        exp_vga.delete();
        exp_drop.delete();
        model.delete();
        bus.disp_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        idle(6);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (exp_mem.size() + exp_vga.size() + exp_drop.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_mem.size() + exp_vga.size() + exp_drop.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
Shares one single-port synchronous VRAM (640x480, 24-bit pixels) between the VGA scan-out path and a host pixel-write port. The display read path has absolute priority and is never stalled. Host writes are buffered in a small FIFO and drained only in cycles with no display demand, which in practice means blanking. The block sits between the VGA timing controller (h_addr, v_addr, valid) and the VRAM macro.

Parameters:
DATA_W, 24, pixel width in bits.
ADDR_W, 19, VRAM word-address width (ceil(log2(307200))).
FIFO_DEPTH, 4, host write FIFO entries; must be a power of 2, at least 2.

Ports:
pclk  in  1  25 MHz pixel/memory clock
reset  in  1  asynchronous, active-high reset
disp_valid  in  1  timing controller visible-region flag
h_addr  in  10  scan column, 0..639, meaningful when disp_valid=1
v_addr  in  10  scan row, 0..479, meaningful when disp_valid=1
vga_data  out  DATA_W  pixel to the colour outputs, registered
host_valid  in  1  host write request
host_ready  out  1  FIFO can accept a write
host_x  in  10  target column
host_y  in  10  target row
host_wdata  in  DATA_W  pixel value
host_drop  out  1  one-cycle pulse: a popped entry was out of range and discarded
mem_en  out  1  VRAM enable, registered
mem_we  out  1  VRAM write enable, registered
mem_addr  out  ADDR_W  VRAM address, registered
mem_wdata  out  DATA_W  VRAM write data, registered
mem_rdata  in  DATA_W  VRAM read data, valid 1 cycle after an enabled read

Behaviour:
- Reset (async assert, deassert sampled on pclk): FIFO emptied, state=ARB_IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_data=0, host_drop=0, host_ready=1 (combinational, driven by the reset-cleared FIFO). Reset mid-write abandons the write; FIFO contents are lost.
- Address arithmetic: addr = y*640 + x, computed as (y<<9)+(y<<7)+x, zero-extended to ADDR_W. No multiplier.
- Handshake: a push occurs when host_valid & host_ready on a pclk edge. host_ready = !full. There is no pass-through when full, even if a pop happens in the same cycle. Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- Arbitration FSM, state register = operation issued this cycle:
  - ARB_DISP if disp_valid=1: next edge drives mem_en=1, mem_we=0, mem_addr = display address.
  - else ARB_HOST if FIFO not empty: pop the head.
    - In range (x<640, y<480): next edge drives mem_en=1, mem_we=1, addr/wdata from the entry.
    - Out of range: mem_en=0, host_drop=1 for one cycle.
  - else ARB_IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their values.
- The display always wins a same-cycle conflict. A host entry waits in the FIFO, with no starvation limit, until disp_valid=0.
- Read pipeline, fixed latency 3:
  - cycle t: disp_valid sampled
  - t+1: mem request on the pins
  - t+2: mem_rdata valid
  - t+3: vga_data updated
- vga_data = mem_rdata when the 2-stage delayed read-valid bit is 1; otherwise vga_data = 0, so blanking shows black. The top level delays hsync/vsync by 3 pclk to match.
- Write-after-write to the same pixel completes in FIFO order. A display read of a pixel with a pending FIFO write returns the old value; this is acceptable.

Decomposition:
- Shared package vga_pkg:
  - H_ACTIVE=640, V_ACTIVE=480, VRAM_WORDS=307200
  - ADDR_W, DATA_W defaults
  - arbitration state enum {ARB_IDLE, ARB_DISP, ARB_HOST}
- One sub-module, vga_wr_fifo: synchronous FIFO of {x, y, data}, same pclk/reset, with full, empty and count outputs.

Test Plan:
- Reset with host_valid=1: during reset mem_en=0, vga_data=0, host_ready=1, host_drop=0, and no push occurs.
- disp_valid=0, push x=5 y=2 data=0xABCDEF: two edges later mem_en=1, mem_we=1, mem_addr=1285, mem_wdata=0xABCDEF; FIFO then empty.
- disp_valid=1, h=639 v=479, with the RAM model returning 0x123456: mem_addr=307199 with mem_we=0 one cycle later; vga_data=0x123456 three cycles after the sample. Drop disp_valid: vga_data=0 three cycles later.
- disp_valid=1 continuously, push 5 writes: the first 4 are accepted, host_ready=0 after the 4th, no mem_we during active. When disp_valid falls, 4 writes are issued in order on consecutive cycles; host_ready returns to 1 after the first pop.
- Push x=640 y=0 during blanking: mem_en stays 0 and host_drop pulses exactly once.
- Assert reset with 3 entries queued and display active: FIFO is empty and all outputs are 0 immediately (async). After release, no stale write is issued.
